// File: rtl/rv32_decode_execute_if.sv
// Decode/execute stage bus: fetched instruction, PC and write-back data in;
// control signals, operands, ALU result and next PC out.
interface rv32_decode_execute_if;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] write_data;
   logic        branch;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic        pc_src;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [31:0] imm32;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] pc_out;

   modport master (
      output instruction, pc, write_data,
      input  branch, alu_op, alu_src, pc_src, mem_read, mem_write, mem_to_reg,
             reg_write, read_data1, read_data2, imm32, zero, alu_result, pc_out
   );

   modport slave (
      input  instruction, pc, write_data,
      output branch, alu_op, alu_src, pc_src, mem_read, mem_write, mem_to_reg,
             reg_write, read_data1, read_data2, imm32, zero, alu_result, pc_out
   );
endinterface

// File: rtl/rv32_decode_execute.sv
// Single-cycle RV32I decode/execute: main controller, register file with
// immediate generator, ALU and next-PC logic. Only the register file is
// clocked; everything else is combinational.
module rv32_decode_execute #(
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst,
   rv32_decode_execute_if.slave bus
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        funct7_5;

   assign instr    = bus.instruction;
   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign funct7_5 = instr[30];

   logic        branch, alu_src, pc_src, mem_read, mem_write, mem_to_reg, reg_write;
   logic [1:0]  alu_op;
   logic [31:0] imm32;
   logic        is_jump;

   // Main controller: unknown opcodes leave every control at 0
   always_comb begin
      branch     = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      pc_src     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      case (opcode)
         OP_R:     begin reg_write = 1'b1; alu_op = 2'b10; pc_src = 1'b1; end
         OP_I:     begin reg_write = 1'b1; alu_src = 1'b1; pc_src = 1'b1; alu_op = 2'b10; end
         OP_LOAD:  begin mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
                         alu_src = 1'b1; pc_src = 1'b1; end
         OP_STORE: begin mem_write = 1'b1; alu_src = 1'b1; pc_src = 1'b1; end
         OP_BR:    begin branch = 1'b1; pc_src = 1'b1; alu_op = 2'b01; end
         OP_JAL,
         OP_JALR:  reg_write = 1'b1;
         OP_LUI:   begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b11; end
         OP_AUIPC: begin reg_write = 1'b1; alu_src = 1'b1; end
         default:  ;
      endcase
   end

   assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);

   // Immediate generator, format picked by opcode, sign taken from bit 31
   always_comb begin
      imm32 = 32'h0;
      case (opcode)
         OP_I, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:               imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BR:                  imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                          instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:       imm32 = {instr[31:12], 12'b0};
         OP_JAL:                 imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                          instr[20], instr[30:21], 1'b0};
         default:                imm32 = 32'h0;
      endcase
   end

   logic [31:0] regs [32];

   // Register file: async clear, write on rising edge, x0 never written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= RESET_VALUE;
      end else if (reg_write && rd != 5'd0) begin
         regs[rd] <= bus.write_data;
      end
   end

   // No bypass: reads see the value before the pending write lands
   logic [31:0] rd1, rd2;
   assign rd1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
   assign rd2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

   logic [31:0] op_a, op_b, alu_result, pc_plus4, pc_out;
   logic        zero;

   assign op_a     = pc_src  ? rd1   : bus.pc;
   assign op_b     = alu_src ? imm32 : rd2;
   assign pc_plus4 = bus.pc + 32'd4;

   // ALU; only R-type may turn add into sub, since I-type bit 30 is immediate
   always_comb begin
      alu_result = 32'h0;
      case (alu_op)
         2'b10: begin
            case (funct3)
               3'b000: alu_result = (opcode == OP_R && funct7_5) ? op_a - op_b : op_a + op_b;
               3'b001: alu_result = op_a << op_b[4:0];
               3'b010: alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
               3'b011: alu_result = {31'b0, op_a < op_b};
               3'b100: alu_result = op_a ^ op_b;
               3'b101: alu_result = funct7_5 ? 32'($signed(op_a) >>> op_b[4:0])
                                             : op_a >> op_b[4:0];
               3'b110: alu_result = op_a | op_b;
               default: alu_result = op_a & op_b;
            endcase
         end
         2'b01:   alu_result = op_a - op_b;
         2'b11:   alu_result = imm32;
         default: alu_result = is_jump ? pc_plus4 : op_a + op_b;
      endcase
   end

   // Zero flag doubles as the branch-taken condition for branches
   always_comb begin
      zero = (alu_result == 32'h0);
      if (alu_op == 2'b01) begin
         case (funct3)
            3'b000:  zero = (op_a == op_b);
            3'b001:  zero = (op_a != op_b);
            3'b100:  zero = $signed(op_a) <  $signed(op_b);
            3'b101:  zero = $signed(op_a) >= $signed(op_b);
            3'b110:  zero = op_a <  op_b;
            3'b111:  zero = op_a >= op_b;
            default: zero = 1'b0;
         endcase
      end
   end

   // Next PC selection
   always_comb begin
      pc_out = pc_plus4;
      if (opcode == OP_JAL)      pc_out = bus.pc + imm32;
      else if (opcode == OP_JALR) pc_out = (rd1 + imm32) & ~32'd1;
      else if (branch && zero)   pc_out = bus.pc + imm32;
   end

   assign bus.branch     = branch;
   assign bus.alu_op     = alu_op;
   assign bus.alu_src    = alu_src;
   assign bus.pc_src     = pc_src;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.reg_write  = reg_write;
   assign bus.read_data1 = rd1;
   assign bus.read_data2 = rd2;
   assign bus.imm32      = imm32;
   assign bus.zero       = zero;
   assign bus.alu_result = alu_result;
   assign bus.pc_out     = pc_out;

endmodule

// File: tb/tb_rv32_decode_execute.sv
// Directed test of the RV32I decode/execute stage with hand-computed results.
module tb_rv32_decode_execute;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   rv32_decode_execute_if bus ();

   rv32_decode_execute #(.RESET_VALUE(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.instruction = 32'h00000013;
      bus.pc = 32'h0;
      bus.write_data = 32'h0;
      #12 rst = 1'b0;
      step();
      // addi x4,x0,0x55
      bus.instruction = 32'h05500213; bus.write_data = 32'h55;
      step();
      bus.instruction = 32'h00020013; // addi x0,x4,0 (read x4)
      #1;
      total_cnt++;
      if (bus.read_data1 !== 32'h55) $display("FAIL pre_reset_x4 got %h exp %h", bus.read_data1, 32'h55);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (bus.read_data1 !== 32'h0) $display("FAIL async_clear_x4 got %h exp 0", bus.read_data1);
      else pass_cnt++;
      #19 rst = 1'b0;
      for (int r = 0; r < 32; r++) begin
         bus.instruction = {7'b0, 5'(r), 5'(r), 3'b000, 5'd0, 7'b0110011};
         #1;
         total_cnt++;
         if (bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0)
            $display("FAIL reset_reg x%0d got %h/%h exp 0", r, bus.read_data1, bus.read_data2);
         else pass_cnt++;
      end
   endtask

   task automatic test_addi();
      step();
      bus.instruction = 32'h00500093; bus.write_data = 32'h5; // addi x1,x0,5
      #1;
      total_cnt++;
      if (bus.imm32 !== 32'h5 || bus.alu_result !== 32'h5 || bus.reg_write !== 1'b1 || bus.alu_src !== 1'b1)
         $display("FAIL addi_ctl got imm=%h res=%h rw=%b src=%b exp 5/5/1/1",
                  bus.imm32, bus.alu_result, bus.reg_write, bus.alu_src);
      else pass_cnt++;
      step();
      bus.instruction = 32'h00108093; bus.write_data = 32'd99; // addi x1,x1,1
      #1;
      total_cnt++;
      if (bus.read_data1 !== 32'h5 || bus.alu_result !== 32'h6)
         $display("FAIL addi_readback got %h/%h exp 5/6", bus.read_data1, bus.alu_result);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.read_data1 !== 32'd99) $display("FAIL reg_update got %0d exp 99", bus.read_data1);
      else pass_cnt++;
      bus.instruction = 32'h00500093; bus.write_data = 32'h5; // restore x1=5
      step();
      bus.instruction = 32'h00700113; bus.write_data = 32'h7; // addi x2,x0,7
      step();
   endtask

   task automatic test_r_type();
      bus.write_data = 32'h0;
      bus.instruction = 32'h002081B3; #1; // add x3,x1,x2
      total_cnt++;
      if (bus.alu_result !== 32'd12 || bus.alu_src !== 1'b0 || bus.pc_src !== 1'b1 || bus.alu_op !== 2'b10)
         $display("FAIL add got res=%h src=%b pcs=%b op=%b exp c/0/1/10",
                  bus.alu_result, bus.alu_src, bus.pc_src, bus.alu_op);
      else pass_cnt++;
      bus.instruction = 32'h402081B3; #1; // sub
      total_cnt++;
      if (bus.alu_result !== 32'hFFFFFFFE) $display("FAIL sub got %h exp fffffffe", bus.alu_result);
      else pass_cnt++;
      bus.instruction = 32'h0020A1B3; #1; // slt
      total_cnt++;
      if (bus.alu_result !== 32'h1) $display("FAIL slt got %h exp 1", bus.alu_result);
      else pass_cnt++;
      bus.instruction = 32'h002091B3; #1; // sll 5<<7
      total_cnt++;
      if (bus.alu_result !== 32'h280) $display("FAIL sll got %h exp 280", bus.alu_result);
      else pass_cnt++;
      bus.instruction = 32'h40008013; #1; // addi x0,x1,0x400: bit30 must not mean sub
      total_cnt++;
      if (bus.alu_result !== 32'h405) $display("FAIL addi_bit30 got %h exp 405", bus.alu_result);
      else pass_cnt++;
   endtask

   task automatic test_branch();
      bus.pc = 32'h100;
      bus.instruction = 32'h00108463; #1; // beq x1,x1,8
      total_cnt++;
      if (bus.branch !== 1'b1 || bus.zero !== 1'b1 || bus.imm32 !== 32'h8 ||
          bus.pc_out !== 32'h108 || bus.reg_write !== 1'b0)
         $display("FAIL beq_taken got br=%b z=%b imm=%h pc=%h rw=%b exp 1/1/8/108/0",
                  bus.branch, bus.zero, bus.imm32, bus.pc_out, bus.reg_write);
      else pass_cnt++;
      bus.instruction = 32'h00208463; #1; // beq x1,x2
      total_cnt++;
      if (bus.zero !== 1'b0 || bus.pc_out !== 32'h104)
         $display("FAIL beq_not_taken got z=%b pc=%h exp 0/104", bus.zero, bus.pc_out);
      else pass_cnt++;
      bus.instruction = 32'h00209463; #1; // bne x1,x2
      total_cnt++;
      if (bus.zero !== 1'b1 || bus.pc_out !== 32'h108)
         $display("FAIL bne got z=%b pc=%h exp 1/108", bus.zero, bus.pc_out);
      else pass_cnt++;
      bus.instruction = 32'h0020C463; #1; // blt x1,x2
      total_cnt++;
      if (bus.zero !== 1'b1 || bus.alu_result !== 32'hFFFFFFFE)
         $display("FAIL blt got z=%b res=%h exp 1/fffffffe", bus.zero, bus.alu_result);
      else pass_cnt++;
   endtask

   task automatic test_upper();
      bus.pc = 32'h10;
      bus.instruction = 32'h123452B7; #1; // lui x5,0x12345
      total_cnt++;
      if (bus.imm32 !== 32'h12345000 || bus.alu_result !== 32'h12345000 || bus.alu_op !== 2'b11)
         $display("FAIL lui got imm=%h res=%h op=%b exp 12345000/12345000/11",
                  bus.imm32, bus.alu_result, bus.alu_op);
      else pass_cnt++;
      bus.instruction = 32'h12345297; #1; // auipc x5,0x12345
      total_cnt++;
      if (bus.alu_result !== 32'h12345010 || bus.pc_src !== 1'b0)
         $display("FAIL auipc got res=%h pcs=%b exp 12345010/0", bus.alu_result, bus.pc_src);
      else pass_cnt++;
   endtask

   task automatic test_mem();
      bus.instruction = 32'hFFC12303; #1; // lw x6,-4(x2)
      total_cnt++;
      if (bus.imm32 !== 32'hFFFFFFFC || bus.alu_result !== 32'h3 || bus.mem_read !== 1'b1 || bus.mem_to_reg !== 1'b1)
         $display("FAIL lw got imm=%h res=%h mr=%b m2r=%b exp fffffffc/3/1/1",
                  bus.imm32, bus.alu_result, bus.mem_read, bus.mem_to_reg);
      else pass_cnt++;
      bus.instruction = 32'hFE20AE23; #1; // sw x2,-4(x1)
      total_cnt++;
      if (bus.imm32 !== 32'hFFFFFFFC || bus.alu_result !== 32'h1 || bus.mem_write !== 1'b1 || bus.reg_write !== 1'b0)
         $display("FAIL sw got imm=%h res=%h mw=%b rw=%b exp fffffffc/1/1/0",
                  bus.imm32, bus.alu_result, bus.mem_write, bus.reg_write);
      else pass_cnt++;
      bus.instruction = 32'hFFFFFFFF; #1; // unknown opcode
      total_cnt++;
      if (bus.reg_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.imm32 !== 32'h0 || bus.pc_out !== 32'h14)
         $display("FAIL unknown got rw=%b mr=%b imm=%h pc=%h exp 0/0/0/14",
                  bus.reg_write, bus.mem_read, bus.imm32, bus.pc_out);
      else pass_cnt++;
   endtask

   task automatic test_x0_and_jumps();
      step();
      bus.instruction = 32'h00900013; bus.write_data = 32'd9; // addi x0,x0,9
      step();
      bus.instruction = 32'h00000013; #1;
      total_cnt++;
      if (bus.read_data1 !== 32'h0) $display("FAIL x0_write got %h exp 0", bus.read_data1);
      else pass_cnt++;
      bus.write_data = 32'h5; // keep x1=5 if a jump's write lands
      bus.pc = 32'h20;
      bus.instruction = 32'h010000EF; #1; // jal x1,+16
      total_cnt++;
      if (bus.alu_result !== 32'h24 || bus.pc_out !== 32'h30 || bus.reg_write !== 1'b1 || bus.alu_op !== 2'b00)
         $display("FAIL jal got res=%h pc=%h rw=%b op=%b exp 24/30/1/00",
                  bus.alu_result, bus.pc_out, bus.reg_write, bus.alu_op);
      else pass_cnt++;
      bus.instruction = 32'h003100E7; #1; // jalr x1,3(x2)
      total_cnt++;
      if (bus.alu_result !== 32'h24 || bus.pc_out !== 32'hA)
         $display("FAIL jalr got res=%h pc=%h exp 24/a", bus.alu_result, bus.pc_out);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_r_type();
      test_branch();
      test_upper();
      test_mem();
      test_x0_and_jumps();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/rv32_decode_execute.md
Name: rv32_decode_execute

Overview:
- Combined decode/execute stage of the single-cycle RV32I CPU: main controller, register-file decoder with immediate generator, and ALU with next-PC logic.
- Takes the fetched instruction and current PC and produces control signals, operands, the ALU result and the next PC.
- Register write-back data comes from the memory/write-back stage via `write_data`.

Parameters:
- RESET_VALUE, 32'h0000_0000, value loaded into every register x1..x31 on reset.

Ports:
- clk  in  1  system clock; register file writes on rising edge
- rst  in  1  asynchronous, active-high reset; clears register file
- instruction  in  32  current RV32I instruction
- pc  in  32  address of current instruction
- write_data  in  32  data written to rd when reg_write=1
- branch  out  1  instruction is a conditional branch
- alu_op  out  2  00 add (load/store/auipc/jal/jalr), 01 branch compare, 10 R/I arithmetic, 11 lui pass-imm
- alu_src  out  1  second ALU operand: 1 imm32, 0 read_data2
- pc_src  out  1  first ALU operand: 0 pc, 1 read_data1
- mem_read  out  1  load
- mem_write  out  1  store
- mem_to_reg  out  1  write-back selects memory data
- reg_write  out  1  rd is written
- read_data1  out  32  x[rs1], combinational
- read_data2  out  32  x[rs2], combinational
- imm32  out  32  sign-extended immediate
- zero  out  1  branch condition / zero flag
- alu_result  out  32  ALU output
- pc_out  out  32  next PC

Behaviour:
- Fields: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].

Control outputs by opcode (all signals not listed are 0):
- R 0110011: reg_write=1, alu_op=10, pc_src=1.
- I-arith 0010011: reg_write, alu_src, pc_src =1; alu_op=10.
- load 0000011: mem_read, mem_to_reg, reg_write, alu_src, pc_src =1; alu_op=00.
- store 0100011: mem_write, alu_src, pc_src =1; alu_op=00.
- branch 1100011: branch=1, pc_src=1, alu_op=01.
- jal 1101111 / jalr 1100111: reg_write=1, alu_op=00.
- lui 0110111: reg_write, alu_src =1; alu_op=11.
- auipc 0010111: reg_write, alu_src =1; pc_src=0; alu_op=00.
- Unknown opcode: all controls 0, so no register write.

Immediate generation (sign-extended from bit 31):
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- U: {[31:12],12'b0}.
- J: {[31],[19:12],[20],[30:21],0}.
- R-type and unknown opcodes: imm32 = 0.

Register file:
- 32x32 registers; x0 always reads 0.
- Reads are combinational; writes happen on posedge clk when reg_write=1 and rd!=0.
- No write-to-read bypass: a read in the same cycle returns the old value.
- rst=1 immediately clears x1..x31 to RESET_VALUE, regardless of clk. A write is not performed while rst=1.

ALU (operands: A = pc_src ? read_data1 : pc; B = alu_src ? imm32 : read_data2):
- alu_op 10: funct3 000 add, or sub only when R-type with funct7[5]=1; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 srl, or sra when funct7[5]=1; 110 or; 111 and.
- Shift amount is B[4:0]. Results are 32-bit with wrap-around, and overflow is ignored.
- alu_op 00: A+B. Exception: for jal/jalr, alu_result = pc+4 (link value).
- alu_op 11: alu_result = imm32.
- alu_op 01: alu_result = A-B. zero = condition by funct3:
  - beq: equal.
  - bne: not equal.
  - blt/bge: signed less / greater-or-equal.
  - bltu/bgeu: unsigned less / greater-or-equal.
  - funct3 010/011: zero=0.
- Non-branch: zero = (alu_result==0).

Next PC:
- jal: pc+imm32.
- jalr: (read_data1+imm32) & ~1.
- branch with zero=1: pc+imm32.
- Otherwise: pc+4.

Timing:
- Every output except register contents is purely combinational from instruction, pc and register state.
- Latency for a register update is one clock edge.

Test Plan:
- Reset: assert rst for 20 ns mid-cycle, then release → read_data1/read_data2 = 0 for every rs1/rs2; any earlier writes are cleared asynchronously.
- addi x1,x0,5 (0x00500093), write_data=5, one posedge → imm32=5, alu_result=5, reg_write=1, alu_src=1. Then rs1=x1 reads 5.
- With x1=5, x2=7: add x3,x1,x2 (0x002081B3) → alu_result=12, alu_src=0; with funct7=0100000 (sub) → 0xFFFFFFFE.
- beq x1,x1,8 (0x00108463), pc=0x100 → branch=1, zero=1, imm32=8, pc_out=0x108, reg_write=0. With x1≠x2, beq x1,x2 → zero=0, pc_out=0x104.
- lui x5,0x12345 (0x123452B7) → imm32=alu_result=0x12345000. auipc with pc=0x10 → 0x12345010.
- Write to x0 (addi x0,x0,9, write_data=9) → x0 still reads 0. jal x1,+16 at pc=0x20 → alu_result=0x24, pc_out=0x30.
